// File: rtl/pll_lock_supervisor_pkg.sv
// Shared state codes and helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  localparam int STATE_W = 3;

  // State codes are visible on the state port (debug / LED), so they are fixed.
  localparam logic [STATE_W-1:0] S_RESET_PLL = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] S_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] S_RELEASE   = 3'd3;
  localparam logic [STATE_W-1:0] S_RUN       = 3'd4;
  localparam logic [STATE_W-1:0] S_FAIL      = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = S_RESET_PLL,
    ST_WAIT_LOCK = S_WAIT_LOCK,
    ST_STABLE    = S_STABLE,
    ST_RELEASE   = S_RELEASE,
    ST_RUN       = S_RUN,
    ST_FAIL      = S_FAIL
  } state_t;

  // 8-bit event counter that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic 1-bit two-flop synchronizer, synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second gives a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: reset PLL, wait for lock, qualify it, then
// release per-domain resets one at a time. Retries lock timeouts, then fails.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int N_DOM         = 4,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 256,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic [N_DOM-1:0]   dom_rst,
  output logic               all_ready,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [7:0]         loss_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  // Terminal counts: timer runs 0..N-1 within a state.
  localparam logic [CNT_W-1:0]   RST_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_END = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STG_END = CNT_W'(STAGGER - 1);
  localparam logic [RETRY_W-1:0] RTY_MAX = RETRY_W'(MAX_RETRY);

  logic lock_s;

  state_t             st_q, st_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [RETRY_W-1:0] rty_q, rty_d;
  logic [N_DOM-1:0]   dom_d;
  logic [7:0]         loss_d;
  logic               pa_d, rdy_d, fail_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign state = st_q;

  // Next-state, timer, retry, domain mask and loss counter.
  always_comb begin
    st_d   = st_q;
    tmr_d  = tmr_q + CNT_W'(1);
    rty_d  = rty_q;
    dom_d  = dom_rst;
    loss_d = loss_cnt;

    if (restart) begin
      // Restart wins over lock loss/timeouts and never counts as a loss.
      st_d  = ST_RESET_PLL;
      tmr_d = '0;
      rty_d = '0;
      dom_d = '1;
    end else begin
      case (st_q)
        ST_RESET_PLL: begin
          dom_d = '1;
          if (tmr_q == RST_END) begin
            st_d  = ST_WAIT_LOCK;
            tmr_d = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            st_d  = ST_STABLE;
            tmr_d = '0;
          end else if (tmr_q == TO_END) begin
            tmr_d = '0;
            if (rty_q < RTY_MAX) begin
              rty_d = rty_q + RETRY_W'(1);
              st_d  = ST_RESET_PLL;
            end else begin
              st_d  = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            // A glitch restarts the whole timeout window; retries untouched.
            st_d  = ST_WAIT_LOCK;
            tmr_d = '0;
          end else if (tmr_q == STB_END) begin
            tmr_d = '0;
            dom_d = dom_rst << 1;
            if (dom_d == '0) begin
              st_d  = ST_RUN;
              rty_d = '0;
            end else begin
              st_d  = ST_RELEASE;
            end
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            st_d   = ST_RESET_PLL;
            tmr_d  = '0;
            dom_d  = '1;
            loss_d = sat_inc8(loss_cnt);
          end else if (st_q == ST_RUN) begin
            tmr_d = '0;
          end else if (tmr_q == STG_END) begin
            // Domains clear LSB first; shifting in zeros releases the next one.
            tmr_d = '0;
            dom_d = dom_rst << 1;
            if (dom_d == '0) begin
              st_d  = ST_RUN;
              rty_d = '0;
            end
          end
        end
        ST_FAIL: begin
          tmr_d = '0;
          dom_d = '1;
        end
        default: begin
          st_d  = ST_RESET_PLL;
          tmr_d = '0;
          dom_d = '1;
        end
      endcase
    end

    pa_d   = (st_d == ST_RESET_PLL) || (st_d == ST_FAIL);
    rdy_d  = (st_d == ST_RUN);
    fail_d = (st_d == ST_FAIL);
  end

  // State register; every output is registered from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_RESET_PLL;
      tmr_q      <= '0;
      rty_q      <= '0;
      pll_areset <= 1'b1;
      dom_rst    <= '1;
      all_ready  <= 1'b0;
      fail       <= 1'b0;
      loss_cnt   <= '0;
    end else begin
      st_q       <= st_d;
      tmr_q      <= tmr_d;
      rty_q      <= rty_d;
      pll_areset <= pa_d;
      dom_rst    <= dom_d;
      all_ready  <= rdy_d;
      fail       <= fail_d;
      loss_cnt   <= loss_d;
    end
  end

endmodule
